// File: rtl/control_multiciclo_if.sv
// control_multiciclo_if
//   Control bus between the multicycle main FSM and the RV32I datapath/memory.
//   master : the control FSM (drives strobes/selects, receives op/zero/memReady)
//   slave  : the datapath + unified memory side
//   Signals:
//     op[6:0]        opcode field of the IR
//     zero           ALU zero flag
//     memReady       memory completed the current access this cycle
//     memReq         memory access request
//     memWrite       memory write enable
//     adrSrc         0 = PC, 1 = ALUOut as memory address
//     irWrite        IR load enable
//     pcWrite        PC load enable
//     regWrite       register file write enable
//     aluSrcA[1:0]   00 = PC, 01 = oldPC, 10 = rs1
//     aluSrcB[1:0]   00 = rs2, 01 = imm, 10 = constant 4
//     aluOp[1:0]     00 = add, 01 = sub, 10 = use funct fields
//     resultSrc[1:0] 00 = ALUOut, 01 = data read, 10 = ALU result
//     fault          1 while trapped
interface control_multiciclo_if;
  logic [6:0] op;
  logic       zero;
  logic       memReady;
  logic       memReq;
  logic       memWrite;
  logic       adrSrc;
  logic       irWrite;
  logic       pcWrite;
  logic       regWrite;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic [1:0] resultSrc;
  logic       fault;

  modport master (
    input  op, zero, memReady,
    output memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite,
           aluSrcA, aluSrcB, aluOp, resultSrc, fault
  );

  modport slave (
    output op, zero, memReady,
    input  memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite,
           aluSrcA, aluSrcB, aluOp, resultSrc, fault
  );
endinterface

// File: rtl/control_multiciclo.sv
// control_multiciclo
//   Main control FSM of the multicycle RV32I core. Sequences the shared ALU,
//   register file, IR/PC and the unified instruction/data memory, waits on the
//   memory ready handshake and traps on a memory timeout.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    control_multiciclo_if.master (op/zero/memReady in, strobes/selects out)
// Parameters:
//   MAX_WAIT  cycles a memory state may wait with memReady=0 before trapping (1..255)
// Build option:
//   CTRL_ILLEGAL_TRAP_EN  defined: unknown opcode in DECODE traps;
//                         undefined: unknown opcode is a NOP back to FETCH.
//
// state    | meaning
// ---------+------------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 and IR load on memReady
// DECODE   | compute branch/jump target oldPC+imm, dispatch on opcode
// MEMADR   | ALUOut <= rs1 + imm for lw/sw
// MEMREAD  | data read at ALUOut, wait for memReady
// MEMWB    | write loaded data to the register file
// MEMWRITE | data write at ALUOut, wait for memReady
// EXECR    | R-type ALU operation rs1 op rs2
// EXECI    | I-type ALU operation rs1 op imm
// ALUWB    | write ALUOut to the register file
// BEQ      | compare rs1-rs2, load target into PC when zero
// JAL      | PC <= target, ALUOut <= oldPC+4 for the link register
// TRAP     | memory timeout or illegal op; left only by reset
module control_multiciclo #(
  parameter int MAX_WAIT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  control_multiciclo_if.master      bus
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy;

  // memReady is masked while reset is held so FETCH cannot raise irWrite/pcWrite
  // on a cycle that is about to be discarded.
  assign rdy = bus.memReady & reset;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bus.memReq    = 1'b0;
    bus.memWrite  = 1'b0;
    bus.adrSrc    = 1'b0;
    bus.irWrite   = 1'b0;
    bus.pcWrite   = 1'b0;
    bus.regWrite  = 1'b0;
    bus.aluSrcA   = 2'b00;
    bus.aluSrcB   = 2'b00;
    bus.aluOp     = 2'b00;
    bus.resultSrc = 2'b00;
    bus.fault     = 1'b0;

    unique case (state_q)
      FETCH: begin
        bus.memReq    = 1'b1;
        bus.aluSrcB   = 2'b10;
        bus.resultSrc = 2'b10;
        if (rdy) begin
          bus.irWrite = 1'b1;
          bus.pcWrite = 1'b1;
          state_d     = DECODE;
        end else if (cnt_q == MAX_CNT) begin
          state_d = TRAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DECODE: begin
        bus.aluSrcA = 2'b01;
        bus.aluSrcB = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:      state_d = TRAP;
`else
          default:      state_d = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        bus.aluSrcA = 2'b10;
        bus.aluSrcB = 2'b01;
        state_d     = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        bus.memReq = 1'b1;
        bus.adrSrc = 1'b1;
        if (rdy)                    state_d = MEMWB;
        else if (cnt_q == MAX_CNT)  state_d = TRAP;
        else                        cnt_d = cnt_q + 1'b1;
      end
      MEMWB: begin
        bus.resultSrc = 2'b01;
        bus.regWrite  = 1'b1;
        state_d       = FETCH;
      end
      MEMWRITE: begin
        bus.memReq   = 1'b1;
        bus.memWrite = 1'b1;
        bus.adrSrc   = 1'b1;
        if (rdy)                    state_d = FETCH;
        else if (cnt_q == MAX_CNT)  state_d = TRAP;
        else                        cnt_d = cnt_q + 1'b1;
      end
      EXECR: begin
        bus.aluSrcA = 2'b10;
        bus.aluOp   = 2'b10;
        state_d     = ALUWB;
      end
      EXECI: begin
        bus.aluSrcA = 2'b10;
        bus.aluSrcB = 2'b01;
        bus.aluOp   = 2'b10;
        state_d     = ALUWB;
      end
      ALUWB: begin
        bus.regWrite = 1'b1;
        state_d      = FETCH;
      end
      BEQ: begin
        bus.aluSrcA = 2'b10;
        bus.aluOp   = 2'b01;
        bus.pcWrite = bus.zero;
        state_d     = FETCH;
      end
      JAL: begin
        bus.aluSrcA = 2'b01;
        bus.aluSrcB = 2'b10;
        bus.pcWrite = 1'b1;
        state_d     = ALUWB;
      end
      TRAP: begin
        bus.fault = 1'b1;
      end
      // unused encodings are treated as a fault
      default: state_d = TRAP;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_control_multiciclo.sv
module tb_control_multiciclo;

  logic clk;
  logic reset;

  control_multiciclo_if ifc ();

  control_multiciclo #(.MAX_WAIT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {memReq,memWrite,adrSrc,irWrite,pcWrite,regWrite,aluSrcA,aluSrcB,aluOp,resultSrc,fault}
  logic [14:0] got;
  assign got = {ifc.memReq, ifc.memWrite, ifc.adrSrc, ifc.irWrite, ifc.pcWrite,
                ifc.regWrite, ifc.aluSrcA, ifc.aluSrcB, ifc.aluOp, ifc.resultSrc,
                ifc.fault};

  function automatic logic [14:0] mk(input logic mr, input logic mw, input logic as,
                                     input logic ir, input logic pw, input logic rw,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] ao, input logic [1:0] rs,
                                     input logic f);
    return {mr, mw, as, ir, pw, rw, a, b, ao, rs, f};
  endfunction

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        zero;
    logic        rdy;
    logic [14:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [14:0] exp_q[$];
  string       name_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  logic [14:0] E_FW, E_FR, E_DEC, E_MADR, E_MRD, E_MWB, E_MWR, E_EXR, E_EXI,
               E_AWB, E_BEQ1, E_BEQ0, E_JAL, E_TRAP;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111,
                         ILL = 7'b1111111;

  task automatic add(input logic r, input logic [6:0] o, input logic z,
                     input logic rd, input logic [14:0] e, input string nm);
    vec_t v;
    v.rst = r; v.op = o; v.zero = z; v.rdy = rd; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check();
    logic [14:0] e;
    string       nm;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_empty: got %h required an entry", got);
      return;
    end
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s: got %b required %b", nm, got, e);
    end
  endtask

  // Drive at negedge, sample 2 time units later, state advances at next posedge.
  task automatic step(input logic r, input logic [6:0] o, input logic z,
                      input logic rd, input logic [14:0] e, input string nm);
    @(negedge clk);
    reset        = r;
    ifc.op       = o;
    ifc.zero     = z;
    ifc.memReady = rd;
    exp_q.push_back(e);
    name_q.push_back(nm);
    #2;
    check();
  endtask

  initial begin
    E_FW   = mk(1,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0);
    E_FR   = mk(1,0,0,1,1,0,2'b00,2'b10,2'b00,2'b10,0);
    E_DEC  = mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0);
    E_MADR = mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0);
    E_MRD  = mk(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0);
    E_MWB  = mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b01,0);
    E_MWR  = mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0);
    E_EXR  = mk(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0);
    E_EXI  = mk(0,0,0,0,0,0,2'b10,2'b01,2'b10,2'b00,0);
    E_AWB  = mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0);
    E_BEQ1 = mk(0,0,0,0,1,0,2'b10,2'b00,2'b01,2'b00,0);
    E_BEQ0 = mk(0,0,0,0,0,0,2'b10,2'b00,2'b01,2'b00,0);
    E_JAL  = mk(0,0,0,0,1,0,2'b01,2'b10,2'b00,2'b00,0);
    E_TRAP = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1);

    reset = 1'b0; ifc.op = '0; ifc.zero = 1'b0; ifc.memReady = 1'b0;
    @(posedge clk);

    // reset held with memReady=1 still looks like FETCH without ready
    add(0, RT, 0, 1, E_FW,  "rst_fetch");
    // R-type
    add(1, RT, 0, 1, E_FR,  "r_fetch");
    add(1, RT, 0, 1, E_DEC, "r_decode");
    add(1, RT, 0, 1, E_EXR, "r_execr");
    add(1, RT, 0, 1, E_AWB, "r_aluwb");
    // I-type
    add(1, IT, 0, 1, E_FR,  "i_fetch");
    add(1, IT, 0, 1, E_DEC, "i_decode");
    add(1, IT, 0, 1, E_EXI, "i_execi");
    add(1, IT, 0, 1, E_AWB, "i_aluwb");
    // lw, 3 wait cycles in MEMREAD
    add(1, LW, 0, 1, E_FR,   "lw_fetch");
    add(1, LW, 0, 1, E_DEC,  "lw_decode");
    add(1, LW, 0, 1, E_MADR, "lw_memadr");
    add(1, LW, 0, 0, E_MRD,  "lw_wait1");
    add(1, LW, 0, 0, E_MRD,  "lw_wait2");
    add(1, LW, 0, 0, E_MRD,  "lw_wait3");
    add(1, LW, 0, 1, E_MRD,  "lw_memread");
    add(1, LW, 0, 1, E_MWB,  "lw_memwb");
    // sw
    add(1, SW, 0, 1, E_FR,   "sw_fetch");
    add(1, SW, 0, 1, E_DEC,  "sw_decode");
    add(1, SW, 0, 1, E_MADR, "sw_memadr");
    add(1, SW, 0, 1, E_MWR,  "sw_memwrite");
    // beq taken / not taken
    add(1, BQ, 1, 1, E_FR,   "beq1_fetch");
    add(1, BQ, 1, 1, E_DEC,  "beq1_decode");
    add(1, BQ, 1, 1, E_BEQ1, "beq1_taken");
    add(1, BQ, 0, 1, E_FR,   "beq0_fetch");
    add(1, BQ, 0, 1, E_DEC,  "beq0_decode");
    add(1, BQ, 0, 1, E_BEQ0, "beq0_not_taken");
    // jal
    add(1, JL, 0, 1, E_FR,  "jal_fetch");
    add(1, JL, 0, 1, E_DEC, "jal_decode");
    add(1, JL, 0, 1, E_JAL, "jal_jal");
    add(1, JL, 0, 1, E_AWB, "jal_aluwb");
    // illegal opcode
    add(1, ILL, 0, 1, E_FR,  "ill_fetch");
    add(1, ILL, 0, 1, E_DEC, "ill_decode");
`ifdef CTRL_ILLEGAL_TRAP_EN
    add(1, ILL, 0, 0, E_TRAP, "ill_trap");
    add(0, ILL, 0, 0, E_TRAP, "ill_trap_rst");
`else
    add(1, ILL, 0, 0, E_FW,   "ill_nop_fetch");
    add(0, ILL, 0, 0, E_FW,   "ill_rst_fetch");
`endif
    // reset in the middle of MEMWRITE
    add(1, SW, 0, 1, E_FR,   "swr_fetch");
    add(1, SW, 0, 1, E_DEC,  "swr_decode");
    add(1, SW, 0, 1, E_MADR, "swr_memadr");
    add(1, SW, 0, 0, E_MWR,  "swr_memwrite");
    add(0, SW, 0, 0, E_MWR,  "swr_rst_edge");
    add(1, SW, 0, 0, E_FW,   "swr_after_rst");

    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].op, vecs[i].zero, vecs[i].rdy, vecs[i].exp, vecs[i].name);

    // Partial wait, then reset: the counter must restart from zero.
    for (int i = 0; i < 5; i++) step(1, RT, 0, 0, E_FW, "pre_rst_wait");
    step(0, RT, 0, 0, E_FW, "cnt_rst");
    // Timeout: 16 FETCH cycles with memReady=0, then TRAP.
    for (int i = 0; i < 16; i++) step(1, RT, 0, 0, E_FW, "to_fetch_wait");
    for (int i = 0; i < 21; i++)
      step(1, 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), E_TRAP, "trap_hold");
    step(0, RT, 0, 1, E_TRAP, "trap_rst_edge");
    step(1, RT, 0, 0, E_FW,   "trap_exit_fetch");

    // memReady arriving on the last allowed wait cycle completes normally.
    for (int i = 0; i < 14; i++) step(1, RT, 0, 0, E_FW, "edge_wait");
    step(1, RT, 0, 1, E_FR,  "edge_ready_wins");
    step(1, RT, 0, 1, E_DEC, "edge_decode");
    step(1, RT, 0, 1, E_EXR, "edge_execr");
    step(1, RT, 0, 1, E_AWB, "edge_aluwb");
    step(1, RT, 0, 0, E_FW,  "edge_fetch");

    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
